branch_resolver: RTL

Two-stage pipelined branch resolution unit for the MIPS CPU. It sits downstream of the register-read stage and consumes operand pairs, which is the consumer side of the compare flags. It derives equal/lower/greater internally and evaluates the branch condition. It produces taken, target, next PC and a mispredict indication over a valid/ready handshake, and keeps saturating statistics counters.

---
 rtl/branch_resolver_if.sv | 37 +++
 rtl/branch_resolver.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/branch_resolver_if.sv
// Request/result bundle for the two-stage branch resolver.
// The master modport drives requests and consumes results. The slave modport is the resolver side.
interface branch_resolver_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       br_op;
    logic [31:0]      pc;
    logic [15:0]      imm;
    logic             pred_taken;

    logic             out_valid;
    logic             out_ready;
    logic             taken;
    logic [31:0]      target;
    logic [31:0]      next_pc;
    logic             mispredict;
    logic [CNT_W-1:0] branch_count;
    logic [CNT_W-1:0] mispredict_count;

    modport master (
        output flush, in_valid, a, b, br_op, pc, imm, pred_taken, out_ready,
        input  in_ready, out_valid, taken, target, next_pc, mispredict,
               branch_count, mispredict_count
    );

    modport slave (
        input  flush, in_valid, a, b, br_op, pc, imm, pred_taken, out_ready,
        output in_ready, out_valid, taken, target, next_pc, mispredict,
               branch_count, mispredict_count
    );
endinterface

// File: rtl/branch_resolver.sv
// Two-stage branch resolver. S1 captures compare flags and the target. S2 evaluates the condition and holds the result.
// Both stages use valid/ready with flush, and the unit keeps saturating handoff and mispredict counters.
module branch_resolver #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    branch_resolver_if.slave  bus
);
    localparam int unsigned PC_W  = 32;
    localparam int unsigned IMM_W = 16;
    localparam int unsigned EXT_W = PC_W - IMM_W - 2;

    localparam logic [2:0] OP_BEQ  = 3'b000;
    localparam logic [2:0] OP_BNE  = 3'b001;
    localparam logic [2:0] OP_BLT  = 3'b010;
    localparam logic [2:0] OP_BGE  = 3'b011;
    localparam logic [2:0] OP_BLTU = 3'b100;
    localparam logic [2:0] OP_BGEU = 3'b101;
    localparam logic [2:0] OP_BGT  = 3'b110;
    localparam logic [2:0] OP_BLE  = 3'b111;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Operand and address arithmetic for S1
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic             w_eq;
    logic             w_lt_s;
    logic             w_lt_u;
    logic [PC_W-1:0]  w_imm_ext;
    logic [PC_W-1:0]  w_pc_plus4;
    logic [PC_W-1:0]  w_target;

    assign w_a        = bus.a;
    assign w_b        = bus.b;
    assign w_eq       = (w_a == w_b);
    assign w_lt_s     = ($signed(w_a) < $signed(w_b));
    assign w_lt_u     = (w_a < w_b);
    assign w_imm_ext  = {{EXT_W{bus.imm[IMM_W-1]}}, bus.imm, 2'b00};
    assign w_pc_plus4 = bus.pc + PC_W'(4);
    assign w_target   = w_pc_plus4 + w_imm_ext;

    // Stage registers
    logic             r_s1_valid;
    logic             r_s1_eq;
    logic             r_s1_lt_s;
    logic             r_s1_lt_u;
    logic [2:0]       r_s1_op;
    logic             r_s1_pred;
    logic [PC_W-1:0]  r_s1_pc4;
    logic [PC_W-1:0]  r_s1_target;

    logic             r_s2_valid;
    logic             r_s2_taken;
    logic [PC_W-1:0]  r_s2_target;
    logic [PC_W-1:0]  r_s2_next_pc;
    logic             r_s2_mis;

    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mis_cnt;

    // Handshake: S2 refills when empty or draining, and S1 frees up as it moves into S2
    logic w_handoff;
    logic w_s2_load;
    logic w_s1_adv;
    logic w_in_ready;
    logic w_accept;

    assign w_handoff  = r_s2_valid & bus.out_ready;
    assign w_s2_load  = ~r_s2_valid | w_handoff;
    assign w_s1_adv   = r_s1_valid & w_s2_load;
    assign w_in_ready = ~i_rst & ~bus.flush & (~r_s1_valid | w_s1_adv);
    assign w_accept   = bus.in_valid & w_in_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_eq     <= 1'b0;
            r_s1_lt_s   <= 1'b0;
            r_s1_lt_u   <= 1'b0;
            r_s1_op     <= 3'b000;
            r_s1_pred   <= 1'b0;
            r_s1_pc4    <= '0;
            r_s1_target <= '0;
        end else begin
            if (bus.flush) begin
                r_s1_valid <= 1'b0;
            end else if (w_accept) begin
                r_s1_valid <= 1'b1;
            end else if (w_s1_adv) begin
                r_s1_valid <= 1'b0;
            end
            if (w_accept) begin
                r_s1_eq     <= w_eq;
                r_s1_lt_s   <= w_lt_s;
                r_s1_lt_u   <= w_lt_u;
                r_s1_op     <= bus.br_op;
                r_s1_pred   <= bus.pred_taken;
                r_s1_pc4    <= w_pc_plus4;
                r_s1_target <= w_target;
            end
        end
    end

    // Condition evaluation from the registered flags
    logic w_cond;

    always_comb begin
        w_cond = 1'b0;
        case (r_s1_op)
            OP_BEQ:  w_cond = r_s1_eq;
            OP_BNE:  w_cond = ~r_s1_eq;
            OP_BLT:  w_cond = r_s1_lt_s;
            OP_BGE:  w_cond = ~r_s1_lt_s;
            OP_BLTU: w_cond = r_s1_lt_u;
            OP_BGEU: w_cond = ~r_s1_lt_u;
            OP_BGT:  w_cond = ~r_s1_lt_s & ~r_s1_eq;
            OP_BLE:  w_cond = r_s1_lt_s | r_s1_eq;
            default: w_cond = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s2_valid   <= 1'b0;
            r_s2_taken   <= 1'b0;
            r_s2_target  <= '0;
            r_s2_next_pc <= '0;
            r_s2_mis     <= 1'b0;
        end else begin
            if (bus.flush) begin
                r_s2_valid <= 1'b0;
            end else if (w_s2_load) begin
                r_s2_valid <= r_s1_valid;
            end
            // Payload only moves with a live entry, so it holds while stalled
            if (w_s1_adv && !bus.flush) begin
                r_s2_taken   <= w_cond;
                r_s2_target  <= r_s1_target;
                r_s2_next_pc <= w_cond ? r_s1_target : r_s1_pc4;
                r_s2_mis     <= w_cond ^ r_s1_pred;
            end
        end
    end

    // Saturating statistics. A handoff on a flush cycle still counts.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_branch_cnt <= '0;
            r_mis_cnt    <= '0;
        end else if (w_handoff) begin
            if (r_branch_cnt != CNT_MAX) begin
                r_branch_cnt <= r_branch_cnt + CNT_W'(1);
            end
            if (r_s2_mis && (r_mis_cnt != CNT_MAX)) begin
                r_mis_cnt <= r_mis_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.in_ready         = w_in_ready;
    assign bus.out_valid        = r_s2_valid;
    assign bus.taken            = r_s2_taken;
    assign bus.target           = r_s2_target;
    assign bus.next_pc          = r_s2_next_pc;
    assign bus.mispredict       = r_s2_mis;
    assign bus.branch_count     = r_branch_cnt;
    assign bus.mispredict_count = r_mis_cnt;
endmodule
